// File: rtl/apb_master.sv
// APB master: turns single user requests into SETUP/ACCESS transfers and
// returns a one-cycle response, with an optional ACCESS-phase timeout.
module apb_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int BYTES_PER_WORD = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic                      req_write,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [BYTES_PER_WORD-1:0] req_strb,
    input  logic [2:0]                req_prot,
    output logic                      psel,
    output logic                      penable,
    output logic [ADDR_WIDTH-1:0]     paddr,
    output logic                      pwrite,
    output logic [DATA_WIDTH-1:0]     pwdata,
    output logic [BYTES_PER_WORD-1:0] pstrb,
    output logic [2:0]                pprot,
    input  logic                      pready,
    input  logic [DATA_WIDTH-1:0]     prdata,
    input  logic                      pslverr,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_error,
    output logic                      rsp_timeout
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e                    state_q;
    logic [CW-1:0]             cnt_q;
    logic                      psel_q, penable_q, pwrite_q;
    logic [ADDR_WIDTH-1:0]     paddr_q;
    logic [DATA_WIDTH-1:0]     pwdata_q;
    logic [BYTES_PER_WORD-1:0] pstrb_q;
    logic [2:0]                pprot_q;
    logic                      rsp_valid_q, rsp_error_q, rsp_timeout_q;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q;

    assign req_ready = (state_q == IDLE) && !preset;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_q   <= SETUP;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        paddr_q   <= req_addr;
                        pwrite_q  <= req_write;
                        pwdata_q  <= req_wdata;
                        pstrb_q   <= req_write ? req_strb : '0;
                        pprot_q   <= req_prot;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                end
                ACCESS: begin
                    // A late pready on the timeout edge still wins over the abort.
                    if (pready) begin
                        state_q       <= IDLE;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_error_q   <= pslverr;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= pwrite_q ? '0 : prdata;
                    end else if (TIMEOUT_EN && cnt_q == CNT_LAST) begin
                        state_q       <= IDLE;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_error_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign pprot       = pprot_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: write, wait-stated read, slave error,
// timeout abort vs. late pready, and reset/busy-request handling.
module tb_apb_master;

    logic        pclk = 1'b0;
    logic        preset;
    logic        req_valid, req_ready, req_write;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        psel, penable, pwrite;
    logic [9:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic        rsp_valid, rsp_error, rsp_timeout;
    logic [31:0] rsp_rdata;

    int n_cmp = 0;
    int n_err = 0;

    apb_master #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .TIMEOUT_CYCLES(16)) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .rsp_timeout(rsp_timeout)
    );

    always #5 pclk = ~pclk;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic wr, input logic [9:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p);
        req_valid = 1'b1; req_write = wr; req_addr = a;
        req_wdata = d;    req_strb  = s;  req_prot = p;
    endtask

    initial begin
        preset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_strb = '0; req_prot = '0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        step(); step();
        chk("rst_psel", {31'd0, psel}, 32'd0);
        chk("rst_penable", {31'd0, penable}, 32'd0);
        chk("rst_paddr", {22'd0, paddr}, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_rsp", {rsp_valid, rsp_error, rsp_timeout, pwrite, pstrb, pprot}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        preset = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Write, pready already high in SETUP (ignored there)
        req(1'b1, 10'h004, 32'hDEADBEEF, 4'hF, 3'b010);
        pready = 1'b1;
        step();
        req_valid = 1'b0;
        chk("wr_setup_sel_en", {30'd0, psel, penable}, 32'd2);
        chk("wr_paddr", {22'd0, paddr}, 32'h004);
        chk("wr_pwdata", pwdata, 32'hDEADBEEF);
        chk("wr_ctl", {24'd0, pwrite, pstrb, pprot}, {24'd0, 1'b1, 4'hF, 3'b010});
        chk("wr_busy_ready", {31'd0, req_ready}, 32'd0);
        step();
        chk("wr_access", {29'd0, psel, penable, rsp_valid}, 32'b110);
        step();
        chk("wr_done", {28'd0, psel, penable, rsp_valid, rsp_error}, 32'b0010);
        chk("wr_rdata", rsp_rdata, 32'd0);
        chk("wr_ready_back", {31'd0, req_ready}, 32'd1);
        step();
        chk("wr_pulse_end", {31'd0, rsp_valid}, 32'd0);
        chk("idle_hold_addr", {22'd0, paddr}, 32'h004);

        // Read with 3 wait states; pslverr/prdata noise while pready low
        req(1'b0, 10'h010, 32'h11111111, 4'hF, 3'b001);
        pready = 1'b0; pslverr = 1'b1; prdata = 32'hBAD0BAD0;
        step();
        req_valid = 1'b0;
        chk("rd_pstrb_zero", {27'd0, pwrite, pstrb}, 32'd0);
        step();
        chk("rd_access", {30'd0, psel, penable}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rd_wait_norsp", {31'd0, rsp_valid}, 32'd0);
            chk("rd_stable", {19'd0, paddr, pwrite, pprot}, {19'd0, 10'h010, 1'b0, 3'b001});
        end
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h12345678;
        step();
        chk("rd_done", {29'd0, rsp_valid, rsp_error, rsp_timeout}, 32'b100);
        chk("rd_rdata", rsp_rdata, 32'h12345678);
        step();

        // Read completing with slave error
        req(1'b0, 10'h020, 32'h0, 4'h0, 3'b000);
        pslverr = 1'b1; prdata = 32'hAAAA5555;
        step(); req_valid = 1'b0;
        step();
        step();
        chk("err_done", {29'd0, rsp_valid, rsp_error, rsp_timeout}, 32'b110);
        chk("err_rdata", rsp_rdata, 32'hAAAA5555);
        pslverr = 1'b0; pready = 1'b0;
        step();
        chk("err_hold", {29'd0, rsp_valid, rsp_error, rsp_timeout}, 32'b010);
        chk("err_hold_rdata", rsp_rdata, 32'hAAAA5555);

        // Timeout: pready low for 16 ACCESS edges
        req(1'b0, 10'h040, 32'h0, 4'h0, 3'b000);
        step(); req_valid = 1'b0;
        step();
        for (int i = 0; i < 15; i++) step();
        chk("to_before", {30'd0, psel, rsp_valid}, 32'b10);
        step();
        chk("to_abort", {28'd0, psel, rsp_valid, rsp_error, rsp_timeout}, 32'b0111);
        chk("to_rdata", rsp_rdata, 32'd0);
        step();
        chk("to_hold", {30'd0, rsp_valid, rsp_timeout}, 32'b01);

        // Same, but pready rises on the timeout edge
        req(1'b0, 10'h080, 32'h0, 4'h0, 3'b000);
        step(); req_valid = 1'b0;
        step();
        for (int i = 0; i < 15; i++) step();
        pready = 1'b1; prdata = 32'hCAFEF00D;
        step();
        chk("late_done", {29'd0, rsp_valid, rsp_error, rsp_timeout}, 32'b100);
        chk("late_rdata", rsp_rdata, 32'hCAFEF00D);
        pready = 1'b0;
        step();

        // Busy-time request ignored, then reset in ACCESS
        req(1'b1, 10'h030, 32'h55AA55AA, 4'h3, 3'b100);
        step();
        req(1'b1, 10'h3FF, 32'hFFFFFFFF, 4'hF, 3'b111);
        step();
        chk("busy_ignored_addr", {22'd0, paddr}, 32'h030);
        chk("busy_ignored_data", pwdata, 32'h55AA55AA);
        chk("busy_ready", {31'd0, req_ready}, 32'd0);
        step();
        chk("busy_still_access", {30'd0, psel, penable}, 32'd3);
        preset = 1'b1; req_valid = 1'b0;
        step();
        chk("rst_access_zero", {22'd0, psel, penable, rsp_valid, pwrite, pstrb, pprot}, 32'd0);
        chk("rst_access_paddr", {22'd0, paddr}, 32'd0);
        chk("rst_access_rsp", {30'd0, rsp_error, rsp_timeout}, 32'd0);
        preset = 1'b0;
        step();
        chk("post_rst_norsp", {29'd0, psel, rsp_valid, req_ready}, 32'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the pwdata, prdata, req_wdata and rsp_rdata width.
REQ-002 Parameter ADDR_WIDTH, default 10, SHALL set the paddr and req_addr width.
REQ-003 Parameter BYTES_PER_WORD, default DATA_WIDTH/8, SHALL set the pstrb and req_strb width.
REQ-004 Parameter TIMEOUT_CYCLES, default 16, SHALL set the maximum number of ACCESS cycles without pready; 0 SHALL disable the timeout.
REQ-005 Ports SHALL be:
pclk  in  1  sole clock; all state updates on the rising edge
preset  in  1  synchronous, active-high reset
req_valid  in  1  user transfer request
req_ready  out  1  request accepted when req_valid and req_ready are both high at a pclk edge
req_addr  in  ADDR_WIDTH  transfer address
req_write  in  1  1 = write, 0 = read
req_wdata  in  DATA_WIDTH  write data
req_strb  in  BYTES_PER_WORD  write byte strobes
req_prot  in  3  protection attributes
psel  out  1  APB select
penable  out  1  APB enable
paddr  out  ADDR_WIDTH  APB address
pwrite  out  1  APB direction
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  BYTES_PER_WORD  APB strobes
pprot  out  3  APB protection
pready  in  1  completer ready
prdata  in  DATA_WIDTH  completer read data
pslverr  in  1  completer error
rsp_valid  out  1  one-cycle transfer-completion pulse
rsp_rdata  out  DATA_WIDTH  read data
rsp_error  out  1  pslverr or timeout
rsp_timeout  out  1  completion caused by timeout

Function
REQ-006 The FSM SHALL have the states IDLE, SETUP and ACCESS.
REQ-007 req_ready SHALL be (state == IDLE) && !preset, driven combinationally; all other outputs SHALL be registered.
REQ-008 IDLE, on acceptance at edge k: go to SETUP at k; capture paddr/pwrite/pwdata/pprot from req_*; psel=1, penable=0.
REQ-009 pstrb SHALL take req_strb for writes and all-zeros for reads.
REQ-010 SETUP SHALL go unconditionally to ACCESS at edge k+1 with penable=1.
REQ-011 paddr/pwrite/pwdata/pstrb/pprot SHALL remain stable from edge k until the transfer ends, and SHALL hold their last values in IDLE.
REQ-012 In ACCESS, pready high at an edge SHALL complete the transfer:
- state to IDLE; psel=0, penable=0
- rsp_valid=1 for exactly one cycle; rsp_error=pslverr; rsp_timeout=0
- rsp_rdata=prdata for reads, 0 for writes
REQ-013 pslverr and prdata SHALL be ignored at every edge where pready is low or the state is not ACCESS.
REQ-014 An ACCESS-cycle counter SHALL clear on entry to ACCESS and increment at each ACCESS edge with pready low.
REQ-015 With TIMEOUT_CYCLES>0, the edge ending the TIMEOUT_CYCLES-th consecutive ACCESS cycle with pready low SHALL abort the transfer:
- state to IDLE; psel=0, penable=0
- rsp_valid=1, rsp_error=1, rsp_timeout=1, rsp_rdata=0
REQ-016 If pready is high on the timeout edge, normal completion (REQ-012) SHALL take priority.
REQ-017 Minimum latency SHALL be 3 edges from acceptance to rsp_valid (k, k+1, pready at k+2); back-to-back transfers SHALL have at least one IDLE cycle between them.
REQ-018 req_valid and req_* SHALL be ignored outside IDLE.
REQ-019 rsp_rdata, rsp_error and rsp_timeout SHALL hold their values until the next completion.

Reset
REQ-020 While preset is high at an edge: state=IDLE; counter=0; every registered output (psel, penable, paddr, pwrite, pwdata, pstrb, pprot, rsp_valid, rsp_rdata, rsp_error, rsp_timeout) SHALL be 0.
REQ-021 Reset asserted in SETUP or ACCESS SHALL abandon the transfer without a rsp_valid pulse.

Verification
REQ-022 Write: addr 0x04, wdata 0xDEADBEEF, strb 0xF, pready=1 in the first ACCESS cycle -> psel at k, penable at k+1, rsp_valid at k+2, rsp_error=0.
REQ-023 Read: addr 0x10, prdata 0x12345678, pready low for 3 ACCESS cycles then high -> pstrb=0, signals stable throughout, rsp_rdata=0x12345678.
REQ-024 Read completing with pslverr=1 -> rsp_error=1, rsp_timeout=0; pslverr=1 while pready=0 -> no effect.
REQ-025 TIMEOUT_CYCLES=16, pready held low -> abort at the 16th ACCESS edge, rsp_error=1, rsp_timeout=1; repeat with pready rising on that edge -> normal completion.
REQ-026 Reset pulsed in ACCESS, and req_valid pulsed while busy -> outputs zero with no rsp_valid; busy-time request not accepted; req_ready returns one cycle after completion.
